// File: rtl/descrambler_23b.sv
// descrambler_23b: receive-side 128b/130b byte descrambler with a 23-bit
// Galois LFSR keystream, block framing from blk_start/sync_hdr, SKP hold and
// optional EIEOS re-seed (enabled by defining DESCRAM_EIEOS_RESEED_EN).
`timescale 1ns/1ps
module descrambler_23b #(
  parameter logic [22:0] SEED       = 23'h1DBFBC,
  parameter logic [7:0]  SKP_SYM    = 8'hAA,
  parameter logic [7:0]  EIEOS_SYM0 = 8'h00
) (
  input  logic       clk_1G,
  input  logic       rst_1G,
  input  logic [7:0] scram_data_in,
  input  logic       data_valid,
  input  logic       blk_start,
  input  logic [1:0] sync_hdr,
  input  logic       en_descram,
  output logic [7:0] descram_data_out,
  output logic       descram_valid,
  output logic       blk_err
);

  localparam int unsigned LFSR_W = 23;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BCNT_W = 4;

  // Feedback taps of G(X) other than bit 0 (bit 0 receives the shifted-out bit)
  localparam logic [LFSR_W-1:0] TAP_MASK = 23'h210124;
  localparam logic [1:0]        HDR_DATA = 2'b10;
  localparam logic [1:0]        HDR_OS   = 2'b01;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DATA_BLK = 2'd1,
    OS_BLK   = 2'd2
  } state_e;

  state_e              state_q;
  logic [BCNT_W-1:0]   bcnt_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [BYTE_W-1:0]   dout_q;
  logic                valid_q;
  logic                err_q;
`ifdef DESCRAM_EIEOS_RESEED_EN
  logic                eieos_q;
`endif

  logic [LFSR_W-1:0]   lfsr_d;
  logic [BYTE_W-1:0]   ks_c;
  logic                is_data_c;
  logic                hdr_bad_c;

  assign descram_data_out = dout_q;
  assign descram_valid    = valid_q;
  assign blk_err          = err_q;

  // Eight serial LFSR steps, bit 0 first: keystream byte and advanced state
  always_comb begin
    logic k;
    k      = 1'b0;
    ks_c   = '0;
    lfsr_d = lfsr_q;
    for (int i = 0; i < 8; i++) begin
      k       = lfsr_d[LFSR_W-1];
      ks_c[i] = k;
      lfsr_d  = {lfsr_d[LFSR_W-2:0], k} ^ ({LFSR_W{k}} & TAP_MASK);
    end
  end

  // Block type of the current byte: a new header on blk_start, else the FSM state
  always_comb begin
    hdr_bad_c = (sync_hdr != HDR_DATA) && (sync_hdr != HDR_OS);
    is_data_c = blk_start ? (sync_hdr == HDR_DATA) : (state_q == DATA_BLK);
  end

  // Block FSM, byte counter, LFSR and registered outputs
  always_ff @(posedge clk_1G) begin
    if (rst_1G) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      lfsr_q  <= SEED;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef DESCRAM_EIEOS_RESEED_EN
      eieos_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (data_valid) begin
        if (!blk_start && state_q == IDLE) begin
          // Stray byte outside any block: flag it, drop it, keep LFSR
          err_q <= 1'b1;
        end else begin
          valid_q <= 1'b1;
          // Data bytes are descrambled; ordered-set bytes pass, SKP holds LFSR
          if (is_data_c) begin
            dout_q <= en_descram ? (scram_data_in ^ ks_c) : scram_data_in;
            lfsr_q <= lfsr_d;
          end else begin
            dout_q <= scram_data_in;
            if (scram_data_in != SKP_SYM) begin
              lfsr_q <= lfsr_d;
            end
          end
          if (blk_start) begin
            // New byte 0; a start inside a block abandons the partial block
            err_q   <= (bcnt_q != '0) || hdr_bad_c;
            bcnt_q  <= BCNT_W'(1);
            state_q <= (sync_hdr == HDR_DATA) ? DATA_BLK : OS_BLK;
`ifdef DESCRAM_EIEOS_RESEED_EN
            eieos_q <= (sync_hdr != HDR_DATA) && (scram_data_in == EIEOS_SYM0);
`endif
          end else begin
            bcnt_q <= bcnt_q + BCNT_W'(1);
            if (bcnt_q == BCNT_W'(15)) begin
              state_q <= IDLE;
`ifdef DESCRAM_EIEOS_RESEED_EN
              eieos_q <= 1'b0;
              if (eieos_q) begin
                lfsr_q <= SEED;
              end
`endif
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_descrambler_23b.sv
// Directed self-checking bench for descrambler_23b.
`timescale 1ns/1ps
module tb_descrambler_23b;

  localparam logic [22:0] SEED = 23'h1DBFBC;
  localparam logic [22:0] POLY = 23'h210125;

  logic       clk_1G = 1'b0;
  logic       rst_1G;
  logic [7:0] scram_data_in;
  logic       data_valid;
  logic       blk_start;
  logic [1:0] sync_hdr;
  logic       en_descram;
  logic [7:0] descram_data_out;
  logic       descram_valid;
  logic       blk_err;

  int n_vec = 0;
  int n_err = 0;
  logic [22:0] m_lfsr;

  descrambler_23b dut (
    .clk_1G          (clk_1G),
    .rst_1G          (rst_1G),
    .scram_data_in   (scram_data_in),
    .data_valid      (data_valid),
    .blk_start       (blk_start),
    .sync_hdr        (sync_hdr),
    .en_descram      (en_descram),
    .descram_data_out(descram_data_out),
    .descram_valid   (descram_valid),
    .blk_err         (blk_err)
  );

  always #5 clk_1G = ~clk_1G;

  // Reference scrambler: returns {keystream byte, state after 8 steps}
  function automatic logic [30:0] scr8(input logic [22:0] s);
    logic [7:0] ks;
    logic       k;
    ks = '0;
    for (int i = 0; i < 8; i++) begin
      k     = s[22];
      ks[i] = k;
      s     = (s << 1) ^ (k ? POLY : 23'h0);
    end
    return {ks, s};
  endfunction

  task automatic cyc(input logic [7:0] d, input logic v, input logic st, input logic [1:0] h);
    @(negedge clk_1G);
    scram_data_in = d;
    data_valid    = v;
    blk_start     = st;
    sync_hdr      = h;
    @(posedge clk_1G);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One scrambled data byte (transmitter in lock with the receiver model)
  task automatic dbyte(input logic st, input logic [7:0] exp_err, input string tag);
    logic [30:0] r;
    logic [7:0]  p;
    p = 8'($urandom);
    r = scr8(m_lfsr);
    cyc(p ^ r[30:23], 1'b1, st, 2'b10);
    chk({tag, "_data"}, descram_data_out, p);
    chk({tag, "_valid"}, 8'(descram_valid), 8'h01);
    chk({tag, "_err"}, 8'(blk_err), exp_err);
    m_lfsr = r[22:0];
  endtask

  initial begin
    logic [30:0] r;
    logic [30:0] t;
    logic [22:0] tx;
    logic [7:0]  b;

    rst_1G = 1'b1; scram_data_in = '0; data_valid = 1'b0;
    blk_start = 1'b0; sync_hdr = 2'b00; en_descram = 1'b1;
    repeat (2) @(posedge clk_1G);
    #1;
    chk("rst_data", descram_data_out, 8'h00);
    chk("rst_valid", 8'(descram_valid), 8'h00);
    chk("rst_err", 8'(blk_err), 8'h00);
    @(negedge clk_1G);
    rst_1G = 1'b0;
    m_lfsr = SEED;

    // First keystream byte from SEED (hand-computed 0x6C)
    cyc(8'h00, 1'b1, 1'b1, 2'b10);
    chk("ks0_data", descram_data_out, 8'h6C);
    chk("ks0_valid", 8'(descram_valid), 8'h01);
    chk("ks0_err", 8'(blk_err), 8'h00);
    r = scr8(m_lfsr);
    m_lfsr = r[22:0];
    for (int i = 1; i < 16; i++) begin
      r = scr8(m_lfsr);
      cyc(8'h00, 1'b1, 1'b0, 2'b10);
      chk("ks_data", descram_data_out, r[30:23]);
      m_lfsr = r[22:0];
    end

    // Loopback of random bytes
    for (int i = 0; i < 16; i++) dbyte(i == 0, 8'h00, "loop");

    // SKP block holds the LFSR
    for (int i = 0; i < 16; i++) begin
      cyc(8'hAA, 1'b1, i == 0, 2'b01);
      chk("skp_data", descram_data_out, 8'hAA);
    end
    for (int i = 0; i < 16; i++) dbyte(i == 0, 8'h00, "skp_next");

    // EIEOS-looking block, then data scrambled from SEED
    for (int i = 0; i < 16; i++) begin
      b = (i % 2 == 1) ? 8'hFF : 8'h00;
      cyc(b, 1'b1, i == 0, 2'b01);
      chk("eieos_data", descram_data_out, b);
      r = scr8(m_lfsr);
      m_lfsr = r[22:0];
    end
`ifdef DESCRAM_EIEOS_RESEED_EN
    m_lfsr = SEED;
`endif
    tx = SEED;
    for (int i = 0; i < 16; i++) begin
      t = scr8(tx);
      r = scr8(m_lfsr);
      cyc(t[30:23], 1'b1, i == 0, 2'b10);
`ifdef DESCRAM_EIEOS_RESEED_EN
      chk("eieos_zero", descram_data_out, 8'h00);
`else
      chk("eieos_nosd", descram_data_out, t[30:23] ^ r[30:23]);
`endif
      tx = t[22:0];
      m_lfsr = r[22:0];
    end
`ifndef DESCRAM_EIEOS_RESEED_EN
    m_lfsr = tx;  // resync model to the transmitter for later steps
    for (int i = 0; i < 16; i++) begin
      cyc(8'hAA, 1'b0, 1'b0, 2'b10);
    end
    // Re-align DUT to model via reset so later blocks stay in lock
    @(negedge clk_1G); rst_1G = 1'b1;
    @(posedge clk_1G); #1;
    @(negedge clk_1G); rst_1G = 1'b0;
    m_lfsr = SEED;
`endif

    // blk_start at bcnt=7: error pulse and resync into a new block
    for (int i = 0; i < 7; i++) dbyte(i == 0, 8'h00, "pre_resync");
    dbyte(1'b1, 8'h01, "resync");
    for (int i = 1; i < 16; i++) dbyte(1'b0, 8'h00, "post_resync");

    // Stray byte in IDLE, then an idle cycle
    cyc(8'h33, 1'b1, 1'b0, 2'b10);
    chk("stray_err", 8'(blk_err), 8'h01);
    chk("stray_valid", 8'(descram_valid), 8'h00);
    cyc(8'h44, 1'b0, 1'b0, 2'b10);
    chk("idle_err", 8'(blk_err), 8'h00);
    chk("idle_valid", 8'(descram_valid), 8'h00);

    // Bad sync header: pass-through, LFSR advances
    for (int i = 0; i < 16; i++) begin
      b = 8'(8'h01 + 8'(i) * 8'h11);
      cyc(b, 1'b1, i == 0, 2'b11);
      chk("hdr11_data", descram_data_out, b);
      chk("hdr11_err", 8'(blk_err), (i == 0) ? 8'h01 : 8'h00);
      r = scr8(m_lfsr);
      m_lfsr = r[22:0];
    end
    for (int i = 0; i < 16; i++) dbyte(i == 0, 8'h00, "after_hdr11");

    // Descrambling disabled: pass-through, LFSR still advances
    en_descram = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      cyc(b, 1'b1, i == 0, 2'b10);
      chk("noen_data", descram_data_out, b);
      r = scr8(m_lfsr);
      m_lfsr = r[22:0];
    end
    en_descram = 1'b1;
    for (int i = 0; i < 16; i++) dbyte(i == 0, 8'h00, "after_noen");

    // Reset at byte 9, then a fresh block from SEED
    for (int i = 0; i < 9; i++) dbyte(i == 0, 8'h00, "pre_rst");
    @(negedge clk_1G);
    rst_1G = 1'b1; scram_data_in = 8'h5C; data_valid = 1'b1; blk_start = 1'b0;
    @(posedge clk_1G); #1;
    chk("midrst_data", descram_data_out, 8'h00);
    chk("midrst_valid", 8'(descram_valid), 8'h00);
    chk("midrst_err", 8'(blk_err), 8'h00);
    @(negedge clk_1G);
    rst_1G = 1'b0; data_valid = 1'b0;
    m_lfsr = SEED;
    cyc(8'h00, 1'b1, 1'b1, 2'b10);
    chk("fresh_ks0", descram_data_out, 8'h6C);
    r = scr8(m_lfsr);
    m_lfsr = r[22:0];
    for (int i = 1; i < 16; i++) dbyte(1'b0, 8'h00, "fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
